// File: rtl/signal_head_driver.sv
// rtl/signal_head_driver.sv - lamp driver for J/C vehicle heads and P walk head
// Optional countdown output is enabled by defining SIG_COUNTDOWN_EN.
module signal_head_driver #(
  parameter int unsigned J_DUR = 15,
  parameter int unsigned P_DUR = 8,
  parameter int unsigned C_DUR = 18,
  parameter int unsigned YEL_T = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       J,
  input  logic       P,
  input  logic       C,
  output logic [2:0] j_rgy,
  output logic [2:0] c_rgy,
  output logic       p_walk,
  output logic       p_dont,
  output logic [7:0] remain,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GO_J,
    S_GO_P,
    S_GO_C,
    S_FAULT
  } state_t;

  localparam logic [7:0] J_LOAD = 8'(J_DUR - 1);
  localparam logic [7:0] P_LOAD = 8'(P_DUR - 1);
  localparam logic [7:0] C_LOAD = 8'(C_DUR - 1);
  localparam logic [7:0] YEL_W  = 8'(YEL_T);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] j_rgy_q, j_rgy_d;
  logic [2:0] c_rgy_q, c_rgy_d;
  logic       p_walk_q, p_walk_d;
  logic       p_dont_q, p_dont_d;
  logic       fault_q, fault_d;

  logic       multi;
  logic       fault_red;
  state_t     req;

  assign multi = (J & P) | (J & C) | (P & C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req     = J ? S_GO_J : (P ? S_GO_P : S_GO_C);
    if (state_q == S_FAULT || multi) begin
      state_d = S_FAULT;
      cnt_d   = 8'd0;
    end else if ({J, P, C} == 3'b000) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end else if (req == state_q) begin
      cnt_d = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
    end else begin
      state_d = req;
      case (req)
        S_GO_J:  cnt_d = J_LOAD;
        S_GO_P:  cnt_d = P_LOAD;
        default: cnt_d = C_LOAD;
      endcase
    end
  end

  // Red bits start high on fault entry, then alternate each cycle.
  assign fault_red = (state_q == S_FAULT) ? ~j_rgy_q[2] : 1'b1;

  always_comb begin
    j_rgy_d  = 3'b100;
    c_rgy_d  = 3'b100;
    p_walk_d = 1'b0;
    p_dont_d = 1'b1;
    fault_d  = 1'b0;
    case (state_d)
      S_GO_J: j_rgy_d = (cnt_d >= YEL_W) ? 3'b001 : 3'b010;
      S_GO_C: c_rgy_d = (cnt_d >= YEL_W) ? 3'b001 : 3'b010;
      S_GO_P: begin
        p_walk_d = (cnt_d >= YEL_W);
        p_dont_d = (cnt_d < YEL_W);
      end
      S_FAULT: begin
        fault_d = 1'b1;
        j_rgy_d = {fault_red, 2'b00};
        c_rgy_d = {fault_red, 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      j_rgy_q  <= 3'b100;
      c_rgy_q  <= 3'b100;
      p_walk_q <= 1'b0;
      p_dont_q <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      j_rgy_q  <= j_rgy_d;
      c_rgy_q  <= c_rgy_d;
      p_walk_q <= p_walk_d;
      p_dont_q <= p_dont_d;
      fault_q  <= fault_d;
    end
  end

  assign j_rgy  = j_rgy_q;
  assign c_rgy  = c_rgy_q;
  assign p_walk = p_walk_q;
  assign p_dont = p_dont_q;
  assign fault  = fault_q;

`ifdef SIG_COUNTDOWN_EN
  logic [7:0] remain_q, remain_d;

  always_comb begin
    remain_d = 8'd0;
    if (state_d == S_GO_J || state_d == S_GO_P || state_d == S_GO_C)
      remain_d = cnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) remain_q <= 8'd0;
    else     remain_q <= remain_d;
  end

  assign remain = remain_q;
`else
  assign remain = 8'd0;
`endif

endmodule
